// File: rtl/rggen_apb_bit_field_initiator.sv
// rggen_apb_bit_field_initiator
//   APB4 slave front end for a bank of registers. Each transfer is captured
//   in the setup phase, replayed to the bit fields as a single-cycle access
//   strobe (ACCESS), and answered on the bus one cycle later (RESPONSE).
//   That gives a fixed single wait state.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_psel .. i_pstrb       APB4 request
//   o_pready, o_prdata,
//   o_pslverr               APB4 response, driven only in RESPONSE
//   o_register_select       one-hot register index, driven only in ACCESS
//   o_bit_field_*           access strobe, masks and write data (ACCESS)
//   i_register_read_data    per-register read data, slice k = register k
module rggen_apb_bit_field_initiator #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int REGISTERS     = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_psel,
  input  logic                            i_penable,
  input  logic [ADDRESS_WIDTH-1:0]        i_paddr,
  input  logic                            i_pwrite,
  input  logic [DATA_WIDTH-1:0]           i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]         i_pstrb,
  output logic                            o_pready,
  output logic [DATA_WIDTH-1:0]           o_prdata,
  output logic                            o_pslverr,
  output logic [REGISTERS-1:0]            o_register_select,
  output logic                            o_bit_field_valid,
  output logic [DATA_WIDTH-1:0]           o_bit_field_read_mask,
  output logic [DATA_WIDTH-1:0]           o_bit_field_write_mask,
  output logic [DATA_WIDTH-1:0]           o_bit_field_write_data,
  input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);
  localparam int BYTE_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BYTE_W);
  // One extra bit so REGISTERS == 2**ADDRESS_WIDTH still compares correctly.
  localparam logic [ADDRESS_WIDTH:0] REG_N = (ADDRESS_WIDTH+1)'(REGISTERS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPONSE} state_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] idx;
    logic                     mapped;
    logic                     write;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [BYTE_W-1:0]        strb;
  } req_t;

  state_t                state_q, state_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rd_slice;
  logic [DATA_WIDTH-1:0] strb_mask;
  logic [REGISTERS-1:0]  sel_onehot;
  logic                  setup;

  // Setup phase only; a lone penable in IDLE is not a transfer.
  assign setup = i_psel && !i_penable;

  // Full address is shifted so the byte-offset bits simply fall away.
  always_comb begin
    req_d.idx    = i_paddr >> ADDR_LSB;
    req_d.mapped = ({1'b0, req_d.idx} < REG_N);
    req_d.write  = i_pwrite;
    req_d.wdata  = i_pwdata;
    req_d.strb   = i_pstrb;
  end

  always_comb begin
    rd_slice   = '0;
    sel_onehot = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      if (req_q.idx == ADDRESS_WIDTH'(k)) begin
        rd_slice      = i_register_read_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < BYTE_W; b++) strb_mask[b*8 +: 8] = {8{req_q.strb[b]}};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup) req_q <= req_d;
      // Read data is sampled at the end of ACCESS so RESPONSE is immune to
      // later changes on the register side.
      if (state_q == ACCESS)
        rdata_q <= (req_q.mapped && !req_q.write) ? rd_slice : '0;
    end
  end

  always_comb begin
    state_d                = state_q;
    o_pready               = 1'b0;
    o_prdata               = '0;
    o_pslverr              = 1'b0;
    o_register_select      = '0;
    o_bit_field_valid      = 1'b0;
    o_bit_field_read_mask  = '0;
    o_bit_field_write_mask = '0;
    o_bit_field_write_data = '0;
    unique case (state_q)
      IDLE: if (setup) state_d = ACCESS;
      ACCESS: begin
        // Runs to completion regardless of psel; there is no abort path.
        state_d = RESPONSE;
        if (req_q.mapped) begin
          o_bit_field_valid      = 1'b1;
          o_register_select      = sel_onehot;
          o_bit_field_write_data = req_q.wdata;
          if (req_q.write) o_bit_field_write_mask = strb_mask;
          else             o_bit_field_read_mask  = '1;
        end
      end
      RESPONSE: begin
        state_d   = IDLE;
        o_pready  = 1'b1;
        o_prdata  = rdata_q;
        o_pslverr = !req_q.mapped;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rggen_apb_bit_field_initiator.sv
module tb_rggen_apb_bit_field_initiator;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int R  = 4;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [BW-1:0]     pstrb;
  logic              pready, pslverr, valid;
  logic [DW-1:0]     prdata, rmask, wmask, wdata;
  logic [R-1:0]      sel;
  logic [R*DW-1:0]   rd_bus;
  logic [DW-1:0]     slices [R];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_vld_cyc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rd_bus = '0;
    for (int k = 0; k < R; k++) rd_bus[k*DW +: DW] = slices[k];
  end

  rggen_apb_bit_field_initiator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REGISTERS(R)) dut (
    .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_paddr(paddr),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
    .o_register_select(sel), .o_bit_field_valid(valid),
    .o_bit_field_read_mask(rmask), .o_bit_field_write_mask(wmask),
    .o_bit_field_write_data(wdata), .i_register_read_data(rd_bus)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full APB transfer starting now (caller is just past a rising edge).
  // Expectations come from the register map: word index, range check,
  // byte-lane expansion of the strobes, read data taken as seen in ACCESS.
  task automatic xfer(input logic [AW-1:0] a, input logic wr,
                      input logic [DW-1:0] wd, input logic [BW-1:0] st);
    int            idx;
    bit            mapped;
    logic [R-1:0]  e_sel;
    logic [DW-1:0] e_wm, e_rm, e_rd;
    idx    = int'(a) / BW;
    mapped = idx < R;
    e_sel  = '0;
    e_wm   = '0;
    e_rm   = '0;
    if (mapped) begin
      e_sel = R'(1 << idx);
      if (wr) for (int b = 0; b < BW; b++) e_wm[b*8 +: 8] = st[b] ? 8'hFF : 8'h00;
      else e_rm = '1;
    end
    psel = 1; penable = 0; paddr = a; pwrite = wr; pwdata = wd; pstrb = st;
    @(negedge clk);
    chk("setup_pready", pready, 0);
    chk("setup_valid", valid, 0);
    @(posedge clk); #1;
    // Bus fields are scrambled after setup; the DUT must use its captured copy.
    penable = 1; paddr = AW'($urandom); pwrite = $urandom; pwdata = $urandom; pstrb = BW'($urandom);
    e_rd = (mapped && !wr) ? slices[idx] : '0;
    @(negedge clk);
    chk("acc_valid", valid, mapped);
    chk("acc_select", sel, e_sel);
    chk("acc_wmask", wmask, e_wm);
    chk("acc_rmask", rmask, e_rm);
    chk("acc_pready", pready, 0);
    if (mapped && wr) chk("acc_wdata", wdata, wd);
    if (valid) last_vld_cyc = cyc;
    @(posedge clk); #1;
    for (int k = 0; k < R; k++) slices[k] = $urandom;
    @(negedge clk);
    chk("rsp_pready", pready, 1);
    chk("rsp_prdata", prdata, e_rd);
    chk("rsp_pslverr", pslverr, !mapped);
    chk("rsp_valid", valid, 0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1; psel = 1; penable = 0; paddr = 0; pwrite = 0; pwdata = 0; pstrb = 0;
    for (int k = 0; k < R; k++) slices[k] = '0;
    #12;
    chk("rst_pready", pready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_select", sel, 0);
    psel = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Directed cases from the register map.
    xfer(8'h08, 1'b1, 32'hA5A55A5A, 4'b0011);
    slices[1] = 32'h12345678;
    xfer(8'h04, 1'b0, 32'h0, 4'h0);
    xfer(8'h10, 1'b0, 32'h0, 4'h0);
    // penable alone in IDLE must not start a transfer.
    psel = 1; penable = 1;
    @(negedge clk); chk("stray_en_valid", valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("stray_en_pready", pready, 0);
    @(posedge clk); #1; psel = 0; penable = 0;

    // Back-to-back: second setup directly after the first response.
    xfer(8'h00, 1'b1, 32'hDEADBEEF, 4'hF);
    c0 = last_vld_cyc;
    chk("b2b_sel0", sel, 0);
    xfer(8'h0C, 1'b0, 32'h0, 4'h0);
    chk("b2b_gap", DW'(last_vld_cyc - c0), 3);

    // Reset while in ACCESS.
    @(posedge clk); #1;
    psel = 1; penable = 0; paddr = 8'h04; pwrite = 0;
    @(posedge clk); #1; penable = 1;
    @(negedge clk); chk("mid_valid_pre", valid, 1);
    #1 rst = 1;
    #1;
    chk("mid_valid", valid, 0);
    chk("mid_select", sel, 0);
    chk("mid_pready", pready, 0);
    @(posedge clk); #1; psel = 0; penable = 0;
    @(negedge clk); rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("mid_no_rsp", pready, 0);
    end
    @(posedge clk); #1;
    xfer(8'h00, 1'b0, 32'h0, 4'h0);

    // Randomized traffic, mostly in range, with random low address bits
    // and random idle gaps.
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 4*R+3));
      xfer(a, 1'($urandom), $urandom, BW'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
